// File: rtl/hockey_pkg.sv
// rtl/hockey_pkg.sv - shared state encoding, launch directions and wall-reflection step
package hockey_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DISPLAY  = 4'd1,
        HIT_A    = 4'd2,
        HIT_B    = 4'd3,
        SEND_A   = 4'd4,
        SEND_B   = 4'd5,
        RESP_A   = 4'd6,
        RESP_B   = 4'd7,
        GOAL_A   = 4'd8,
        GOAL_B   = 4'd9,
        GAMEOVER = 4'd10
    } state_t;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_POS      = 2'b01;
    localparam logic [1:0] DIR_NEG      = 2'b10;

    // One Y step; a puck heading into a wall bounces back off it in the same step.
    function automatic int step_y(input int y, input logic [1:0] dir, input int h);
        if (dir == DIR_POS) return (y == h - 1) ? h - 2 : y + 1;
        if (dir == DIR_NEG) return (y == 0) ? 1 : y - 1;
        return y;
    endfunction

    function automatic logic [1:0] step_dir(input int y, input logic [1:0] dir, input int h);
        if (dir == DIR_POS && y == h - 1) return DIR_NEG;
        if (dir == DIR_NEG && y == 0) return DIR_POS;
        return dir;
    endfunction

endpackage

// File: rtl/hockey_field_ctrl_timer.sv
// rtl/hockey_field_ctrl_timer.sv - hockey_tick_timer: loadable-period counter with one-cycle terminal tick
module hockey_tick_timer #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] cnt;

    assign tick = en && !clr && (cnt == period - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hockey_field_ctrl.sv
// rtl/hockey_field_ctrl.sv - two-player hockey game FSM; HOCKEY_SPEEDUP_EN shortens the step period on each return
module hockey_field_ctrl
    import hockey_pkg::*;
#(
    parameter int FIELD_W     = 5,
    parameter int FIELD_H     = 5,
    parameter int TICK_CYCLES = 200,
    parameter int WIN_SCORE   = 3,
    parameter int SCORE_W     = 3,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H),
    localparam int TW = $clog2(TICK_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_a,
    input  logic               btn_b,
    input  logic [1:0]         dir_a,
    input  logic [1:0]         dir_b,
    input  logic [YW-1:0]      y_in_a,
    input  logic [YW-1:0]      y_in_b,
    output logic [XW-1:0]      x_coord,
    output logic [YW-1:0]      y_coord,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [3:0]         state_o,
    output logic               game_over,
    output logic               winner
);

    // One spare bit so a power-of-two TICK_CYCLES still fits as a period value.
    localparam int PW = TW + 1;
    localparam logic [PW-1:0]      TICK_P = PW'(TICK_CYCLES);
    localparam logic [XW-1:0]      X_LAST = XW'(FIELD_W - 1);
    localparam logic [YW:0]        FH     = (YW + 1)'(FIELD_H);
    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);

    state_t        state;
    logic [1:0]    dir;
    logic          server;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tick;
    logic [PW-1:0] period;
    logic [PW-1:0] send_period;
    logic          hit_a;
    logic          hit_b;
    logic          serve_a;
    logic          serve_b;

`ifdef HOCKEY_SPEEDUP_EN
    localparam logic [PW-1:0] STEP_DEC = PW'(TICK_CYCLES / 8);
    localparam logic [PW-1:0] MIN_P    = PW'(TICK_CYCLES / 4);
    logic [PW-1:0] speed;
    assign send_period = speed;
`else
    assign send_period = TICK_P;
`endif

    assign hit_a   = btn_a && (y_in_a == y_coord);
    assign hit_b   = btn_b && (y_in_b == y_coord);
    assign serve_a = btn_a && ({1'b0, y_in_a} < FH);
    assign serve_b = btn_b && ({1'b0, y_in_b} < FH);
    assign period  = (state == SEND_A || state == SEND_B) ? send_period : TICK_P;
    assign state_o = state;

    // Timer is held at zero outside timed states, so every timed state starts a fresh count.
    always_comb begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state)
            DISPLAY, SEND_A, SEND_B, GOAL_A, GOAL_B: tmr_en = 1'b1;
            RESP_A: begin tmr_en = 1'b1; tmr_clr = hit_a; end
            RESP_B: begin tmr_en = 1'b1; tmr_clr = hit_b; end
            default: tmr_clr = 1'b1;
        endcase
    end

    hockey_tick_timer #(.PW(PW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_coord   <= '0;
            y_coord   <= '0;
            dir       <= DIR_STRAIGHT;
            server    <= 1'b0;
            score_a   <= '0;
            score_b   <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
`ifdef HOCKEY_SPEEDUP_EN
            speed     <= TICK_P;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (btn_a) begin
                        server <= 1'b0;
                        state  <= DISPLAY;
                    end else if (btn_b) begin
                        server <= 1'b1;
                        state  <= DISPLAY;
                    end
                end
                DISPLAY: if (tick) state <= server ? HIT_B : HIT_A;
                HIT_A: if (serve_a) begin
                    x_coord <= '0;
                    y_coord <= y_in_a;
                    dir     <= dir_a;
                    state   <= SEND_B;
                end
                HIT_B: if (serve_b) begin
                    x_coord <= X_LAST;
                    y_coord <= y_in_b;
                    dir     <= dir_b;
                    state   <= SEND_A;
                end
                SEND_A: if (tick) begin
                    x_coord <= x_coord - 1'b1;
                    y_coord <= YW'(step_y(int'(y_coord), dir, FIELD_H));
                    dir     <= step_dir(int'(y_coord), dir, FIELD_H);
                    if (x_coord == XW'(1)) state <= RESP_A;
                end
                SEND_B: if (tick) begin
                    x_coord <= x_coord + 1'b1;
                    y_coord <= YW'(step_y(int'(y_coord), dir, FIELD_H));
                    dir     <= step_dir(int'(y_coord), dir, FIELD_H);
                    if (x_coord == X_LAST - 1'b1) state <= RESP_B;
                end
                RESP_A: begin
                    if (hit_a) begin
                        x_coord <= XW'(1);
                        y_coord <= YW'(step_y(int'(y_coord), dir_a, FIELD_H));
                        dir     <= step_dir(int'(y_coord), dir_a, FIELD_H);
                        state   <= SEND_B;
`ifdef HOCKEY_SPEEDUP_EN
                        speed   <= (speed - STEP_DEC < MIN_P) ? MIN_P : speed - STEP_DEC;
`endif
                    end else if (tick) begin
                        if (score_b < WIN_S) score_b <= score_b + 1'b1;
                        state <= GOAL_B;
`ifdef HOCKEY_SPEEDUP_EN
                        speed <= TICK_P;
`endif
                    end
                end
                RESP_B: begin
                    if (hit_b) begin
                        x_coord <= X_LAST - 1'b1;
                        y_coord <= YW'(step_y(int'(y_coord), dir_b, FIELD_H));
                        dir     <= step_dir(int'(y_coord), dir_b, FIELD_H);
                        state   <= SEND_A;
`ifdef HOCKEY_SPEEDUP_EN
                        speed   <= (speed - STEP_DEC < MIN_P) ? MIN_P : speed - STEP_DEC;
`endif
                    end else if (tick) begin
                        if (score_a < WIN_S) score_a <= score_a + 1'b1;
                        state <= GOAL_A;
`ifdef HOCKEY_SPEEDUP_EN
                        speed <= TICK_P;
`endif
                    end
                end
                GOAL_A: if (tick) begin
                    if (score_a == WIN_S) begin
                        state     <= GAMEOVER;
                        game_over <= 1'b1;
                        winner    <= 1'b0;
                    end else begin
                        state <= HIT_B;
                    end
                end
                GOAL_B: if (tick) begin
                    if (score_b == WIN_S) begin
                        state     <= GAMEOVER;
                        game_over <= 1'b1;
                        winner    <= 1'b1;
                    end else begin
                        state <= HIT_A;
                    end
                end
                GAMEOVER: state <= GAMEOVER;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hockey_field_ctrl.sv
// tb/tb_hockey_field_ctrl.sv - directed self-checking bench for hockey_field_ctrl (default parameters)
module tb_hockey_field_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a, btn_b;
    logic [1:0] dir_a, dir_b;
    logic [2:0] y_in_a, y_in_b;
    logic [2:0] x_coord, y_coord;
    logic [2:0] score_a, score_b;
    logic [3:0] state_o;
    logic       game_over, winner;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_DISPLAY = 4'd1, S_HIT_A = 4'd2, S_HIT_B = 4'd3;
    localparam logic [3:0] S_SEND_A = 4'd4, S_SEND_B = 4'd5, S_RESP_A = 4'd6, S_RESP_B = 4'd7;
    localparam logic [3:0] S_GOAL_A = 4'd8, S_GOAL_B = 4'd9, S_GAMEOVER = 4'd10;

    hockey_field_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .dir_a     (dir_a),
        .dir_b     (dir_b),
        .y_in_a    (y_in_a),
        .y_in_b    (y_in_b),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .score_a   (score_a),
        .score_b   (score_b),
        .state_o   (state_o),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state_o == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_a = 0; btn_b = 0; dir_a = 0; dir_b = 0; y_in_a = 0; y_in_b = 0;
        cyc(2);
        tests_run++;
        if ({state_o, x_coord, y_coord, score_a, score_b, game_over, winner} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: state=%0d x=%0d y=%0d sa=%0d sb=%0d go=%0d w=%0d, required all 0",
                     state_o, x_coord, y_coord, score_a, score_b, game_over, winner);
        end
        rst = 1'b0;
        cyc(5);
        tests_run++;
        if (state_o !== S_IDLE) begin
            tests_failed++;
            $display("FAIL idle_hold: state=%0d required %0d", state_o, S_IDLE);
        end
    endtask

    task automatic test_serve_b;
        btn_b = 1'b1;
        cyc(1);
        btn_b = 1'b0;
        tests_run++;
        if (state_o !== S_DISPLAY) begin
            tests_failed++;
            $display("FAIL idle_to_display: state=%0d required %0d", state_o, S_DISPLAY);
        end
        cyc(199);
        tests_run++;
        if (state_o !== S_DISPLAY) begin
            tests_failed++;
            $display("FAIL display_len_200: state=%0d required %0d", state_o, S_DISPLAY);
        end
        cyc(1);
        tests_run++;
        if (state_o !== S_HIT_B) begin
            tests_failed++;
            $display("FAIL display_to_hit_b: state=%0d required %0d", state_o, S_HIT_B);
        end
        y_in_b = 3'd2; dir_b = 2'b00; btn_b = 1'b1;
        cyc(1);
        btn_b = 1'b0;
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_SEND_A, 3'd4, 3'd2}) begin
            tests_failed++;
            $display("FAIL serve_b: state=%0d x=%0d y=%0d required state=%0d x=4 y=2",
                     state_o, x_coord, y_coord, S_SEND_A);
        end
        cyc(199);
        tests_run++;
        if (x_coord !== 3'd4) begin
            tests_failed++;
            $display("FAIL step_not_early: x=%0d required 4", x_coord);
        end
        cyc(1);
        tests_run++;
        if ({x_coord, y_coord} !== {3'd3, 3'd2}) begin
            tests_failed++;
            $display("FAIL first_step: x=%0d y=%0d required x=3 y=2", x_coord, y_coord);
        end
        cyc(400);
        tests_run++;
        if ({state_o, x_coord} !== {S_SEND_A, 3'd1}) begin
            tests_failed++;
            $display("FAIL step_x1: state=%0d x=%0d required state=%0d x=1", state_o, x_coord, S_SEND_A);
        end
        cyc(200);
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_RESP_A, 3'd0, 3'd2}) begin
            tests_failed++;
            $display("FAIL reach_resp_a: state=%0d x=%0d y=%0d required state=%0d x=0 y=2",
                     state_o, x_coord, y_coord, S_RESP_A);
        end
    endtask

    task automatic test_miss_a;
        cyc(199);
        tests_run++;
        if (state_o !== S_RESP_A) begin
            tests_failed++;
            $display("FAIL resp_window_len: state=%0d required %0d", state_o, S_RESP_A);
        end
        cyc(1);
        tests_run++;
        if ({state_o, score_a, score_b} !== {S_GOAL_B, 3'd0, 3'd1}) begin
            tests_failed++;
            $display("FAIL miss_a_goal_b: state=%0d sa=%0d sb=%0d required state=%0d sa=0 sb=1",
                     state_o, score_a, score_b, S_GOAL_B);
        end
        cyc(199);
        tests_run++;
        if (state_o !== S_GOAL_B) begin
            tests_failed++;
            $display("FAIL goal_len: state=%0d required %0d", state_o, S_GOAL_B);
        end
        cyc(1);
        tests_run++;
        if (state_o !== S_HIT_A) begin
            tests_failed++;
            $display("FAIL goal_to_hit_a: state=%0d required %0d", state_o, S_HIT_A);
        end
    endtask

    task automatic test_reflect;
        y_in_a = 3'd5; dir_a = 2'b10; btn_a = 1'b1;
        cyc(2);
        tests_run++;
        if (state_o !== S_HIT_A) begin
            tests_failed++;
            $display("FAIL serve_row_out_of_range: state=%0d required %0d", state_o, S_HIT_A);
        end
        y_in_a = 3'd0;
        cyc(1);
        btn_a = 1'b0;
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_SEND_B, 3'd0, 3'd0}) begin
            tests_failed++;
            $display("FAIL serve_a: state=%0d x=%0d y=%0d required state=%0d x=0 y=0",
                     state_o, x_coord, y_coord, S_SEND_B);
        end
        cyc(200);
        tests_run++;
        if ({x_coord, y_coord} !== {3'd1, 3'd1}) begin
            tests_failed++;
            $display("FAIL bottom_wall_bounce: x=%0d y=%0d required x=1 y=1", x_coord, y_coord);
        end
        cyc(600);
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_RESP_B, 3'd4, 3'd4}) begin
            tests_failed++;
            $display("FAIL reach_resp_b: state=%0d x=%0d y=%0d required state=%0d x=4 y=4",
                     state_o, x_coord, y_coord, S_RESP_B);
        end
        y_in_b = 3'd4; dir_b = 2'b01; btn_b = 1'b1;
        cyc(1);
        btn_b = 1'b0;
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_SEND_A, 3'd3, 3'd3}) begin
            tests_failed++;
            $display("FAIL return_b_top_bounce: state=%0d x=%0d y=%0d required state=%0d x=3 y=3",
                     state_o, x_coord, y_coord, S_SEND_A);
        end
        cyc(600);
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_RESP_A, 3'd0, 3'd0}) begin
            tests_failed++;
            $display("FAIL descend_to_resp_a: state=%0d x=%0d y=%0d required state=%0d x=0 y=0",
                     state_o, x_coord, y_coord, S_RESP_A);
        end
        y_in_a = 3'd3; dir_a = 2'b10; btn_a = 1'b1;
        cyc(1);
        tests_run++;
        if (state_o !== S_RESP_A) begin
            tests_failed++;
            $display("FAIL wrong_row_no_hit: state=%0d required %0d", state_o, S_RESP_A);
        end
        y_in_a = 3'd0;
        cyc(1);
        btn_a = 1'b0;
        tests_run++;
        if ({state_o, x_coord, y_coord} !== {S_SEND_B, 3'd1, 3'd1}) begin
            tests_failed++;
            $display("FAIL return_a_bounce: state=%0d x=%0d y=%0d required state=%0d x=1 y=1",
                     state_o, x_coord, y_coord, S_SEND_B);
        end
        cyc(200);
        tests_run++;
        if ({x_coord, y_coord} !== {3'd2, 3'd2}) begin
            tests_failed++;
            $display("FAIL dir_after_bounce: x=%0d y=%0d required x=2 y=2", x_coord, y_coord);
        end
    endtask

    task automatic test_reset_mid;
        cyc(50);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({state_o, x_coord, y_coord, score_a, score_b, game_over, winner} !== 19'd0) begin
            tests_failed++;
            $display("FAIL async_reset_mid_send: state=%0d x=%0d y=%0d sa=%0d sb=%0d required all 0",
                     state_o, x_coord, y_coord, score_a, score_b);
        end
        cyc(1);
        rst = 1'b0;
        cyc(3);
        tests_run++;
        if (state_o !== S_IDLE) begin
            tests_failed++;
            $display("FAIL idle_after_reset: state=%0d required %0d", state_o, S_IDLE);
        end
    endtask

    task automatic test_game_over;
        bit ok;
        dir_a = 2'b00; dir_b = 2'b00; y_in_a = 3'd0; y_in_b = 3'd0;
        btn_a = 1'b1; btn_b = 1'b1;
        cyc(1);
        btn_a = 1'b0; btn_b = 1'b0;
        cyc(200);
        tests_run++;
        if (state_o !== S_HIT_A) begin
            tests_failed++;
            $display("FAIL both_buttons_server_a: state=%0d required %0d", state_o, S_HIT_A);
        end
        for (int r = 1; r <= 3; r++) begin
            if (r == 1) begin
                btn_a = 1'b1; cyc(1); btn_a = 1'b0;
            end else begin
                btn_b = 1'b1; cyc(1); btn_b = 1'b0;
                wait_for(S_RESP_A, 1000, ok);
                tests_run++;
                if (!ok) begin
                    tests_failed++;
                    $display("FAIL round%0d_resp_a: state=%0d required %0d", r, state_o, S_RESP_A);
                end
                btn_a = 1'b1; cyc(1); btn_a = 1'b0;
            end
            wait_for(S_RESP_B, 1000, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL round%0d_resp_b: state=%0d required %0d", r, state_o, S_RESP_B);
            end
            wait_for(S_GOAL_A, 300, ok);
            tests_run++;
            if (!ok || score_a !== 3'(r) || score_b !== 3'd0) begin
                tests_failed++;
                $display("FAIL round%0d_goal_a: state=%0d sa=%0d sb=%0d required state=%0d sa=%0d sb=0",
                         r, state_o, score_a, score_b, S_GOAL_A, r);
            end
            wait_for((r == 3) ? S_GAMEOVER : S_HIT_B, 300, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL round%0d_goal_exit: state=%0d", r, state_o);
            end
        end
        tests_run++;
        if ({game_over, winner} !== 2'b10) begin
            tests_failed++;
            $display("FAIL game_over_flags: game_over=%0d winner=%0d required 1 0", game_over, winner);
        end
        btn_a = 1'b1; btn_b = 1'b1;
        cyc(500);
        btn_a = 1'b0; btn_b = 1'b0;
        tests_run++;
        if ({state_o, score_a, score_b, game_over} !== {S_GAMEOVER, 3'd3, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL gameover_absorbing: state=%0d sa=%0d sb=%0d go=%0d required state=%0d sa=3 sb=0 go=1",
                     state_o, score_a, score_b, game_over, S_GAMEOVER);
        end
    endtask

    initial begin
        test_reset;
        test_serve_b;
        test_miss_a;
        test_reflect;
        test_reset_mid;
        test_game_over;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
